logic_gates_seq_ctrl: RTL and testbench
=======================================

Name: logic_gates_seq_ctrl

Overview:
Self-test sequencer for the two-input gate datapath (inputs iA/iB; outputs oAnd/oOr/oNot).
- On a start request it drives all four input combinations into the gate block, holding each vector for a programmable number of cycles.
- At the end of each hold it samples the three gate outputs and compares them against golden values.
- It reports pass/fail plus a per-vector error map. It sits between a board-level start button/controller and one gate instance.

Parameters:
HOLD_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255
CNT_W, 8, hold-counter width; must satisfy 2**CNT_W > HOLD_CYCLES

Ports:
iClk  input  1  system clock, rising edge
iRst  input  1  synchronous, active-high reset
iStart  input  1  start request; sampled only in IDLE or DONE
iAbort  input  1  abort request; sampled every cycle
iAnd  input  1  gate block oAnd
iOr  input  1  gate block oOr
iNot  input  1  gate block oNot
oA  output  1  drives gate block iA
oB  output  1  drives gate block iB
oVecIdx  output  2  index k of vector currently driven
oBusy  output  1  sequence in progress
oDone  output  1  one-cycle pulse on successful completion
oPass  output  1  1 = last completed run had zero mismatches
oErrMap  output  4  bit k = mismatch seen at vector k

Behaviour:
- Reset (iRst=1 at a rising edge): state IDLE. oA, oB, oVecIdx, oBusy, oDone, oPass and oErrMap are all 0. Reset overrides all other inputs, including mid-run.
- Vector order, k=0..3: oA=k[0], oB=k[1], giving (A,B) = 00, 10, 01, 11.
- Golden values: And=A&B, Or=A|B, Not=~A.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN when iStart=1 and iAbort=0 at edge E0.
  - At E0: oErrMap<=0, oPass<=0, oBusy<=1, k<=0, hold count<=0, oA/oB<=vector 0.
- RUN: each vector is driven for exactly HOLD_CYCLES cycles. Vector k occupies edges E0+k*H to E0+(k+1)*H, where H=HOLD_CYCLES.
  - At edge E0+(k+1)*H, iAnd/iOr/iNot are compared with golden(k). Any mismatch sets oErrMap[k].
  - At the same edge, for k<3: k<=k+1, counter<=0 and the next vector is driven.
- RUN -> DONE at edge E0+4H.
  - oBusy<=0, oDone<=1 for exactly one cycle, oPass<=(final oErrMap==0). The compare result of vector 3 is included.
  - oA/oB<=0, oVecIdx<=0.
- DONE: oPass and oErrMap hold until the next accepted start or reset. DONE behaves like IDLE for start acceptance.
- Run length: 4*HOLD_CYCLES busy cycles; with the default that is 16.
- iStart while RUN is ignored; no restart and no queuing.
- iAbort=1 in RUN -> IDLE at the next edge.
  - oBusy<=0, oA/oB<=0, oVecIdx<=0, no oDone pulse, oPass<=0.
  - oErrMap keeps the bits captured so far.
- iAbort and iStart asserted together in IDLE/DONE: abort wins and the start is ignored.
- HOLD_CYCLES=1: every cycle of RUN is a sample edge; the run is 4 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then idle: hold iRst 2 cycles, iStart=0 -> all outputs 0 for 10 cycles.
- Correct gate, HOLD_CYCLES=4, pulse iStart.
  - oBusy high exactly 16 cycles.
  - oA/oB sequence 00,10,01,11, each held 4 cycles.
  - oDone single pulse, oPass=1, oErrMap=4'b0000.
- Fault injection, gate model with oOr stuck-at-0 -> oErrMap=4'b1110, oPass=0, oDone pulsed.
- Further fault injections:
  - oAnd stuck-at-1 -> oErrMap=4'b0111.
  - oNot wired as A (non-inverted) -> oErrMap=4'b1111.
- Abort and busy restart:
  - Assert iAbort on cycle 6 of a run (during vector 1) -> IDLE next edge, no oDone, oPass=0, oErrMap bits for vector 0 only retained.
  - iStart pulses mid-run are ignored (run length unchanged).
- Edge cases:
  - HOLD_CYCLES=1 -> 4-cycle run, correct oErrMap.
  - iRst asserted mid-run -> all outputs 0 next edge.
  - iStart+iAbort same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/logic_gates_seq_ctrl.sv
// Self-test sequencer for a two-input gate block.
// Walks the four input vectors and checks And/Or/Not outputs.
module logic_gates_seq_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic       iAbort,
  input  logic       iAnd,
  input  logic       iOr,
  input  logic       iNot,
  output logic       oA,
  output logic       oB,
  output logic [1:0] oVecIdx,
  output logic       oBusy,
  output logic       oDone,
  output logic       oPass,
  output logic [3:0] oErrMap
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] holdCnt;
  logic             sampleNow;
  logic             mismatch;
  logic [3:0]       errNext;
  logic [1:0]       idxNext;

  // Compare gate outputs with golden values of the vector on oA/oB
  always_comb begin
    sampleNow = (holdCnt == LAST);
    mismatch  = (iAnd != (oA & oB))
              | (iOr  != (oA | oB))
              | (iNot != ~oA);
    errNext   = oErrMap;
    errNext[oVecIdx] = oErrMap[oVecIdx] | mismatch;
    idxNext   = oVecIdx + 2'd1;
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      holdCnt <= '0;
      oA      <= 1'b0;
      oB      <= 1'b0;
      oVecIdx <= 2'd0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oPass   <= 1'b0;
      oErrMap <= 4'd0;
    end else begin
      oDone <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (iStart && !iAbort) begin
            state   <= RUN;
            holdCnt <= '0;
            oA      <= 1'b0;
            oB      <= 1'b0;
            oVecIdx <= 2'd0;
            oBusy   <= 1'b1;
            oPass   <= 1'b0;
            oErrMap <= 4'd0;
          end
        end
        RUN: begin
          if (iAbort) begin
            state   <= IDLE;
            holdCnt <= '0;
            oA      <= 1'b0;
            oB      <= 1'b0;
            oVecIdx <= 2'd0;
            oBusy   <= 1'b0;
            oPass   <= 1'b0;
          end else if (sampleNow) begin
            holdCnt <= '0;
            oErrMap <= errNext;
            if (oVecIdx == 2'd3) begin
              state   <= DONE;
              oA      <= 1'b0;
              oB      <= 1'b0;
              oVecIdx <= 2'd0;
              oBusy   <= 1'b0;
              oDone   <= 1'b1;
              oPass   <= (errNext == 4'd0);
            end else begin
              oVecIdx <= idxNext;
              oA      <= idxNext[0];
              oB      <= idxNext[1];
            end
          end else begin
            holdCnt <= holdCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_gates_seq_ctrl.sv
// Bench for logic_gates_seq_ctrl: two instances (hold 4 and hold 1)
// driven together and compared against an elapsed-time model.
module tb_logic_gates_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   failures = 0;

  logic d0A, d0B, d0Busy, d0Done, d0Pass;
  logic [1:0] d0Idx;
  logic [3:0] d0Err;
  logic g0And, g0Or, g0Not;
  logic d1A, d1B, d1Busy, d1Done, d1Pass;
  logic [1:0] d1Idx;
  logic [3:0] d1Err;
  logic g1And, g1Or, g1Not;
  logic [10:0] obs0, obs1;

  always #5 clk = ~clk;

  // Gate block under test, with selectable faults
  function automatic logic [2:0] gate(input logic a, input logic b,
                                      input int m);
    logic an, o, n;
    an = a & b;
    o  = a | b;
    n  = ~a;
    case (m)
      1: o = 1'b0;
      2: an = 1'b1;
      3: n = a;
      default: ;
    endcase
    return {an, o, n};
  endfunction

  assign {g0And, g0Or, g0Not} = gate(d0A, d0B, mode);
  assign {g1And, g1Or, g1Not} = gate(d1A, d1B, mode);
  assign obs0 = {d0Busy, d0Done, d0Pass, d0Err, d0Idx, d0A, d0B};
  assign obs1 = {d1Busy, d1Done, d1Pass, d1Err, d1Idx, d1A, d1B};

  logic_gates_seq_ctrl #(.HOLD_CYCLES(4), .CNT_W(8)) dut0 (
    .iClk(clk), .iRst(rst), .iStart(start), .iAbort(abort),
    .iAnd(g0And), .iOr(g0Or), .iNot(g0Not),
    .oA(d0A), .oB(d0B), .oVecIdx(d0Idx), .oBusy(d0Busy),
    .oDone(d0Done), .oPass(d0Pass), .oErrMap(d0Err)
  );

  logic_gates_seq_ctrl #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .iClk(clk), .iRst(rst), .iStart(start), .iAbort(abort),
    .iAnd(g1And), .iOr(g1Or), .iNot(g1Not),
    .oA(d1A), .oB(d1B), .oVecIdx(d1Idx), .oBusy(d1Busy),
    .oDone(d1Done), .oPass(d1Pass), .oErrMap(d1Err)
  );

  // Reference model: run flag plus edges elapsed since start
  int         hv[2] = '{4, 1};
  bit         mRun[2] = '{0, 0};
  int         mT[2] = '{0, 0};
  logic [3:0] mErr[2] = '{4'd0, 4'd0};
  bit         mPass[2] = '{0, 0};
  bit         mDone[2] = '{0, 0};

  task automatic modelStep(input int i);
    int k, a, b;
    logic [2:0] g;
    if (rst) begin
      mRun[i] = 0; mErr[i] = 4'd0; mPass[i] = 0; mDone[i] = 0;
    end else begin
      mDone[i] = 0;
      if (mRun[i]) begin
        if (abort) begin
          mRun[i] = 0; mPass[i] = 0;
        end else begin
          if ((mT[i] + 1) % hv[i] == 0) begin
            k = (mT[i] + 1) / hv[i] - 1;
            a = k % 2;
            b = k / 2;
            g = gate(a[0], b[0], mode);
            if (g[2] != ((a * b) != 0) || g[1] != ((a + b) != 0)
                || g[0] != (a == 0))
              mErr[i][k] = 1'b1;
            if (k == 3) begin
              mRun[i] = 0; mDone[i] = 1; mPass[i] = (mErr[i] == 4'd0);
            end
          end
          mT[i] = mT[i] + 1;
        end
      end else if (start && !abort) begin
        mRun[i] = 1; mT[i] = 0; mErr[i] = 4'd0; mPass[i] = 0;
      end
    end
  endtask

  function automatic logic [10:0] expOut(input int i);
    int idx;
    idx = mRun[i] ? mT[i] / hv[i] : 0;
    return {mRun[i], mDone[i], mPass[i], mErr[i],
            idx[1:0], idx[0], idx[1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (obs0 !== 11'd0 || obs1 !== 11'd0) begin
      failures++;
      $display("FAIL reset got=%b/%b want=0", obs0, obs1);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs0 !== 11'd0 || obs1 !== 11'd0) begin
        failures++;
        $display("FAIL idle c%0d got=%b/%b want=0", c, obs0, obs1);
      end
    end
  endtask

  task automatic test_pass_run();
    int busy0, done0, busy1, done1;
    logic [1:0] ev;
    busy0 = 0; done0 = 0; busy1 = 0; done1 = 0;
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      checks++;
      if (obs0 !== expOut(0) || obs1 !== expOut(1)) begin
        failures++;
        $display("FAIL pass_run c%0d got=%b/%b want=%b/%b",
                 c, obs0, obs1, expOut(0), expOut(1));
      end
      if (c < 16) begin
        ev = 2'(c / 4);
        checks++;
        if ({d0B, d0A} !== ev) begin
          failures++;
          $display("FAIL vec_seq c%0d got=%b want=%b", c, {d0B, d0A}, ev);
        end
      end
      busy0 += int'(d0Busy); done0 += int'(d0Done);
      busy1 += int'(d1Busy); done1 += int'(d1Done);
      tick();
    end
    checks++;
    if (busy0 != 16 || done0 != 1 || d0Pass !== 1'b1 || d0Err !== 4'd0) begin
      failures++;
      $display("FAIL pass_sum got busy=%0d done=%0d pass=%b err=%b want 16 1 1 0000",
               busy0, done0, d0Pass, d0Err);
    end
    checks++;
    if (busy1 != 4 || done1 != 1 || d1Pass !== 1'b1) begin
      failures++;
      $display("FAIL pass_sum_h1 got busy=%0d done=%0d pass=%b want 4 1 1",
               busy1, done1, d1Pass);
    end
  endtask

  task automatic test_faults();
    logic [3:0] want[3] = '{4'b1110, 4'b0111, 4'b1111};
    int done0, done1;
    for (int m = 1; m <= 3; m++) begin
      done0 = 0; done1 = 0;
      mode = m;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
        checks++;
        if (obs0 !== expOut(0) || obs1 !== expOut(1)) begin
          failures++;
          $display("FAIL fault%0d c%0d got=%b/%b want=%b/%b",
                   m, c, obs0, obs1, expOut(0), expOut(1));
        end
        done0 += int'(d0Done); done1 += int'(d1Done);
        tick();
      end
      checks++;
      if (d0Err !== want[m-1] || d1Err !== want[m-1] || d0Pass !== 1'b0
          || d1Pass !== 1'b0 || done0 != 1 || done1 != 1) begin
        failures++;
        $display("FAIL fault%0d_sum got err=%b/%b pass=%b/%b done=%0d/%0d want err=%b pass=0 done=1",
                 m, d0Err, d1Err, d0Pass, d1Pass, done0, done1, want[m-1]);
      end
    end
  endtask

  task automatic test_abort();
    int done0;
    done0 = 0;
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (d0Busy !== 1'b0 || d0Err !== 4'b0001 || d0Pass !== 1'b0
        || d0Done !== 1'b0 || {d0B, d0A, d0Idx} !== 4'd0) begin
      failures++;
      $display("FAIL abort got busy=%b err=%b pass=%b done=%b want 0 0001 0 0",
               d0Busy, d0Err, d0Pass, d0Done);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      done0 += int'(d0Done);
      checks++;
      if (obs0 !== expOut(0) || obs1 !== expOut(1)) begin
        failures++;
        $display("FAIL abort_after c%0d got=%b/%b want=%b/%b",
                 c, obs0, obs1, expOut(0), expOut(1));
      end
    end
    checks++;
    if (done0 != 0) begin
      failures++;
      $display("FAIL abort_nodone got=%0d want=0", done0);
    end
  endtask

  task automatic test_busy_restart();
    int busy0;
    busy0 = 0;
    mode = 0;
    start = 1'b1;
    tick();
    for (int c = 0; c < 24; c++) begin
      busy0 += int'(d0Busy);
      checks++;
      if (obs0 !== expOut(0) || obs1 !== expOut(1)) begin
        failures++;
        $display("FAIL restart c%0d got=%b/%b want=%b/%b",
                 c, obs0, obs1, expOut(0), expOut(1));
      end
      start = (c == 3 || c == 7 || c == 10 || c == 15);
      tick();
    end
    start = 1'b0;
    checks++;
    if (busy0 != 16) begin
      failures++;
      $display("FAIL restart_len got=%0d want=16", busy0);
    end
  endtask

  task automatic test_hold1();
    int busy1;
    busy1 = 0;
    mode = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      busy1 += int'(d1Busy);
      tick();
    end
    checks++;
    if (busy1 != 4 || d1Err !== 4'b1111 || d1Pass !== 1'b0) begin
      failures++;
      $display("FAIL hold1 got busy=%0d err=%b pass=%b want 4 1111 0",
               busy1, d1Err, d1Pass);
    end
  endtask

  task automatic test_rst_midrun();
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (obs0 !== 11'd0 || obs1 !== 11'd0) begin
      failures++;
      $display("FAIL rst_midrun got=%b/%b want=0", obs0, obs1);
    end
  endtask

  task automatic test_start_abort();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (d0Busy !== 1'b0 || d1Busy !== 1'b0 || d0Err !== 4'd0) begin
        failures++;
        $display("FAIL start_abort c%0d got busy=%b/%b want 0/0",
                 c, d0Busy, d1Busy);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) mode = int'($urandom_range(0, 3));
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 96) == 0);
      tick();
      checks++;
      if (obs0 !== expOut(0) || obs1 !== expOut(1)) begin
        failures++;
        $display("FAIL random c%0d got=%b/%b want=%b/%b",
                 c, obs0, obs1, expOut(0), expOut(1));
      end
    end
    start = 1'b0;
    abort = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_abort();
    test_pass_run();
    test_faults();
    test_abort();
    test_busy_restart();
    test_hold1();
    test_rst_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
